// File: rtl/bicg_pkg.sv
// bicg_pkg: shared types and constants for the BiCG kernel engine.
//   state_t : engine FSM states
//   FP_W    : float word width (IEEE bits are never interpreted here)
//   MODE_S / MODE_Q : bit positions in the mode field
//   FP_ZERO : bit pattern written when clearing s
package bicg_pkg;
  localparam int FP_W   = 32;
  localparam int MODE_S = 0;
  localparam int MODE_Q = 1;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [3:0] {
    IDLE, CLR, ROW, RD_A, RD_P, RD_S, MUL_S, ADD_S, WR_S, MUL_Q, ADD_Q, WR_Q, DONE
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/bicg_engine_fp_issue_timer.sv
// fp_issue_timer: latency tracker shared by the fmul and fadd units.
//   clk, reset      : clock, synchronous active-low reset
//   load, lat       : on the issue cycle, arm the timer with the unit latency
//   result_valid    : high exactly lat cycles after the load cycle
module fp_issue_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] lat,
  output logic          result_valid
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)             cnt <= '0;
    else if (load)          cnt <= lat;
    else if (cnt != '0)     cnt <= cnt - CW'(1);
  end

  // cnt reaches 1 on the lat-th cycle after load; it then parks at 0.
  assign result_valid = (cnt == CW'(1));
endmodule

// File: rtl/bicg_engine.sv
// bicg_engine: BiCG kernel over a word-addressed single-port RAM.
//   s[j] += r[i]*A[i][j]   (mode[MODE_S]),  q[i] = sum_j A[i][j]*p[j]  (mode[MODE_Q])
// Ports:
//   clk, reset (sync, active low)
//   start, mode, base_a/r/p/s/q : run launch; mode and bases latched in IDLE
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : RAM port, 1-cycle read latency
//   f_mul_a/b, f_mul_res, f_add_a/b, f_add_res : external pipelined FP cores
//   busy, done : busy from the cycle after start through done; done is a pulse
module bicg_engine
  import bicg_pkg::*;
#(
  parameter int NX      = 30,
  parameter int NY      = 30,
  parameter int ADDR_W  = 10,
  parameter int MUL_LAT = 6,
  parameter int ADD_LAT = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_r,
  input  logic [ADDR_W-1:0] base_p,
  input  logic [ADDR_W-1:0] base_s,
  input  logic [ADDR_W-1:0] base_q,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [FP_W-1:0]   mem_wdata,
  input  logic [FP_W-1:0]   mem_rdata,
  output logic [FP_W-1:0]   f_mul_a,
  output logic [FP_W-1:0]   f_mul_b,
  input  logic [FP_W-1:0]   f_mul_res,
  output logic [FP_W-1:0]   f_add_a,
  output logic [FP_W-1:0]   f_add_b,
  input  logic [FP_W-1:0]   f_add_res,
  output logic              busy,
  output logic              done
);
  localparam int IW = (NX > 1) ? $clog2(NX) : 1;
  localparam int JW = (NY > 1) ? $clog2(NY) : 1;
  localparam int CW = $clog2(max2(MUL_LAT, ADD_LAT) + 1);

  state_t            state, state_n;
  logic              ph;        // 0 = issue cycle, 1 = capture / wait
  logic [IW-1:0]     i;
  logic [JW-1:0]     j;
  logic [1:0]        mode_r;
  logic [ADDR_W-1:0] br, bp, bs, bq;
  logic [ADDR_W-1:0] a_ptr;     // walks A row-major, so wrap is free
  logic [FP_W-1:0]   r_val, a_val, p_val, s_val, prod, q_acc;

  logic              tmr_load, tv;
  logic [CW-1:0]     tmr_lat;
  logic              elem_end, row_end;
  logic              i_last, j_last;
  state_t            after_row, after_elem;

  assign i_last     = (i == IW'(NX-1));
  assign j_last     = (j == JW'(NY-1));
  assign after_row  = i_last ? DONE : ROW;
  assign after_elem = !j_last ? RD_A : (mode_r[MODE_Q] ? WR_Q : after_row);
  assign row_end    = (state == WR_Q) || (elem_end && j_last && !mode_r[MODE_Q]);

  fp_issue_timer #(.CW(CW)) u_tmr (
    .clk(clk), .reset(reset), .load(tmr_load), .lat(tmr_lat), .result_valid(tv)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = FP_ZERO;
    f_mul_a   = FP_ZERO;
    f_mul_b   = FP_ZERO;
    f_add_a   = FP_ZERO;
    f_add_b   = FP_ZERO;
    tmr_load  = 1'b0;
    tmr_lat   = '0;
    elem_end  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start) state_n = (mode == 2'b00) ? DONE : (mode[MODE_S] ? CLR : ROW);
      CLR: begin
        mem_en = 1'b1; mem_we = 1'b1; mem_addr = bs + ADDR_W'(j);
        if (j_last) state_n = ROW;
      end
      ROW: begin
        mem_en = !ph; mem_addr = ph ? '0 : br + ADDR_W'(i);
        if (ph) state_n = RD_A;
      end
      RD_A: begin
        mem_en = !ph; mem_addr = ph ? '0 : a_ptr;
        if (ph) state_n = mode_r[MODE_Q] ? RD_P : RD_S;
      end
      RD_P: begin
        mem_en = !ph; mem_addr = ph ? '0 : bp + ADDR_W'(j);
        if (ph) state_n = mode_r[MODE_S] ? RD_S : MUL_Q;
      end
      RD_S: begin
        mem_en = !ph; mem_addr = ph ? '0 : bs + ADDR_W'(j);
        if (ph) state_n = MUL_S;
      end
      // FP states: operands stay on the bus for the whole state, which
      // covers the hold requirement since the sources don't change.
      MUL_S: begin
        f_mul_a = r_val; f_mul_b = a_val;
        tmr_load = !ph; tmr_lat = CW'(MUL_LAT);
        if (ph && tv) state_n = ADD_S;
      end
      ADD_S: begin
        f_add_a = s_val; f_add_b = prod;
        tmr_load = !ph; tmr_lat = CW'(ADD_LAT);
        if (ph && tv) state_n = WR_S;
      end
      WR_S: begin
        mem_en = 1'b1; mem_we = 1'b1; mem_addr = bs + ADDR_W'(j); mem_wdata = s_val;
        if (mode_r[MODE_Q]) state_n = MUL_Q;
        else begin state_n = after_elem; elem_end = 1'b1; end
      end
      MUL_Q: begin
        f_mul_a = a_val; f_mul_b = p_val;
        tmr_load = !ph; tmr_lat = CW'(MUL_LAT);
        if (ph && tv) state_n = ADD_Q;
      end
      ADD_Q: begin
        f_add_a = q_acc; f_add_b = prod;
        tmr_load = !ph; tmr_lat = CW'(ADD_LAT);
        if (ph && tv) begin state_n = after_elem; elem_end = 1'b1; end
      end
      WR_Q: begin
        mem_en = 1'b1; mem_we = 1'b1; mem_addr = bq + ADDR_W'(i); mem_wdata = q_acc;
        state_n = after_row;
      end
      DONE: begin
        done = 1'b1; state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ph <= 1'b0; i <= '0; j <= '0; mode_r <= '0;
      br <= '0; bp <= '0; bs <= '0; bq <= '0; a_ptr <= '0;
      r_val <= FP_ZERO; a_val <= FP_ZERO; p_val <= FP_ZERO;
      s_val <= FP_ZERO; prod  <= FP_ZERO; q_acc <= FP_ZERO;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_r <= mode; a_ptr <= base_a;
          br <= base_r; bp <= base_p; bs <= base_s; bq <= base_q;
          i <= '0; j <= '0; ph <= 1'b0;
        end
        CLR: j <= j_last ? '0 : j + JW'(1);
        ROW, RD_A, RD_P, RD_S: begin
          ph <= !ph;
          if (ph) begin
            case (state)
              ROW:     begin r_val <= mem_rdata; q_acc <= FP_ZERO; end
              RD_A:    a_val <= mem_rdata;
              RD_P:    p_val <= mem_rdata;
              default: s_val <= mem_rdata;
            endcase
          end
        end
        MUL_S, ADD_S, MUL_Q, ADD_Q: begin
          if (!ph) ph <= 1'b1;
          else if (tv) begin
            ph <= 1'b0;
            case (state)
              ADD_S:   s_val <= f_add_res;
              ADD_Q:   q_acc <= f_add_res;
              default: prod  <= f_mul_res;
            endcase
          end
        end
        default: ;
      endcase
      if (elem_end) begin
        a_ptr <= a_ptr + ADDR_W'(1);
        j     <= j_last ? '0 : j + JW'(1);
      end
      if (row_end && !i_last) i <= i + IW'(1);
    end
  end
endmodule

// File: tb/tb_bicg_engine.sv
module tb_bicg_engine;
  localparam int NX = 2, NY = 2, AW = 10, ML = 2, AL = 3;
  localparam logic [AW-1:0] BR = 10'd16, BP = 10'd20, BS = 10'd24, BQ = 10'd28;
  localparam logic [AW-1:0] BS1 = 10'd25, BQ1 = 10'd29;
  localparam logic [31:0] F0 = 32'h0, F1 = 32'h3F80_0000, F2 = 32'h4000_0000,
                          F3 = 32'h4040_0000, F4 = 32'h4080_0000, F6 = 32'h40C0_0000,
                          F7 = 32'h40E0_0000, SPRE = 32'h0000_007F, QPRE = 32'h0000_0055;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [AW-1:0] base_a = '0, base_r = BR, base_p = BP, base_s = BS, base_q = BQ;
  logic mem_en, mem_we, busy, done;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, f_mul_a, f_mul_b, f_mul_res, f_add_a, f_add_b, f_add_res;

  always #5 clk = ~clk;

  bicg_engine #(.NX(NX), .NY(NY), .ADDR_W(AW), .MUL_LAT(ML), .ADD_LAT(AL)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .base_a(base_a), .base_r(base_r), .base_p(base_p), .base_s(base_s), .base_q(base_q),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .f_mul_a(f_mul_a), .f_mul_b(f_mul_b), .f_mul_res(f_mul_res),
    .f_add_a(f_add_a), .f_add_b(f_add_b), .f_add_res(f_add_res), .busy(busy), .done(done)
  );

  // single <-> double conversion for normal numbers and zero
  function automatic real f2r(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:23] == 8'd0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction
  function automatic logic [31:0] r2f(input real x);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(x);
    if (d[62:0] == 63'd0) return 32'h0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // external FP cores: LAT-deep pipelines
  logic [31:0] mp [ML];
  logic [31:0] ap [AL];
  always @(posedge clk) begin
    mp[0] <= r2f(f2r(f_mul_a) * f2r(f_mul_b));
    for (int k = 1; k < ML; k++) mp[k] <= mp[k-1];
    ap[0] <= r2f(f2r(f_add_a) + f2r(f_add_b));
    for (int k = 1; k < AL; k++) ap[k] <= ap[k-1];
  end
  assign f_mul_res = mp[ML-1];
  assign f_add_res = ap[AL-1];

  // RAM model with a bench-side preload port
  logic [31:0] mem [0:1023];
  logic pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  // activity monitor
  logic mon_clr = 1'b0;
  int n_acc, n_swr, n_qwr, n_done, rd_n;
  logic [AW-1:0] rd_log [0:63];
  always @(posedge clk) begin
    if (mon_clr) begin
      n_acc <= 0; n_swr <= 0; n_qwr <= 0; n_done <= 0; rd_n <= 0;
    end else begin
      if (mem_en) n_acc <= n_acc + 1;
      if (mem_en && mem_we && (mem_addr == BS || mem_addr == BS1)) n_swr <= n_swr + 1;
      if (mem_en && mem_we && (mem_addr == BQ || mem_addr == BQ1)) n_qwr <= n_qwr + 1;
      if (mem_en && !mem_we && rd_n < 64) begin rd_log[rd_n] <= mem_addr; rd_n <= rd_n + 1; end
      if (done) n_done <= n_done + 1;
    end
  end

  int n_pass = 0, n_chk = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk); #1 pre_we = 1'b0;
  endtask

  task automatic preset(input logic [AW-1:0] ba);
    wr(ba, F1); wr(ba + AW'(1), F2); wr(ba + AW'(2), F3); wr(ba + AW'(3), F4);
    wr(BR, F1); wr(BR + AW'(1), F1); wr(BP, F1); wr(BP + AW'(1), F1);
    wr(BS, SPRE); wr(BS1, SPRE); wr(BQ, QPRE); wr(BQ1, QPRE);
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1; @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  // Launch a run; lat = cycles from the start-sampling cycle to done (-1 on timeout).
  // poke > 0 pulses start with a different mode at that cycle of the run.
  task automatic run(input logic [1:0] m, input logic [AW-1:0] ba, input int poke, output int lat);
    clr_mon();
    mode = m; base_a = ba; start = 1'b1; lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (n == 1) start = 1'b0;
      if (poke > 0 && n == poke) begin start = 1'b1; mode = 2'b10; end
      if (poke > 0 && n == poke + 1) begin start = 1'b0; mode = m; end
      if (done) begin lat = n; break; end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [1:0] m; logic [AW-1:0] ba; int cyc;
    logic [31:0] s0, s1, q0, q1; int acc, swr, qwr;
  } vec_t;
  vec_t vt [5];

  initial begin
    int lat, n1, n2, idle_n;
    vt[0] = '{2'b01, 10'd0,    55, F4,   F6,   QPRE, QPRE, 16, 6, 0};
    vt[1] = '{2'b10, 10'd0,    51, SPRE, SPRE, F3,   F7,   12, 0, 2};
    vt[2] = '{2'b11, 10'd0,    93, F4,   F6,   F3,   F7,   22, 6, 2};
    vt[3] = '{2'b00, 10'd0,     1, SPRE, SPRE, QPRE, QPRE,  0, 0, 0};
    vt[4] = '{2'b01, 10'd1022, 55, F4,   F6,   QPRE, QPRE, 16, 6, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_ops", f_mul_a | f_mul_b | f_add_a | f_add_b | mem_wdata, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      preset(vt[v].ba);
      run(vt[v].m, vt[v].ba, 0, lat);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vt[v].cyc));
      chk($sformatf("v%0d_s0", v), mem[BS],  vt[v].s0);
      chk($sformatf("v%0d_s1", v), mem[BS1], vt[v].s1);
      chk($sformatf("v%0d_q0", v), mem[BQ],  vt[v].q0);
      chk($sformatf("v%0d_q1", v), mem[BQ1], vt[v].q1);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_acc", v), 32'(n_acc), 32'(vt[v].acc));
      chk($sformatf("v%0d_s_wr", v), 32'(n_swr), 32'(vt[v].swr));
      chk($sformatf("v%0d_q_wr", v), 32'(n_qwr), 32'(vt[v].qwr));
      chk($sformatf("v%0d_done_cnt", v), 32'(n_done), 1);
      chk($sformatf("v%0d_idle", v), 32'(busy), 0);
    end

    // A addresses of the wrapped run (last vector): r0,A,s0,A,s1,r1,A,s0,A,s1
    chk("wrap_rd_n", 32'(rd_n), 10);
    chk("wrap_a00", 32'(rd_log[1]), 1022);
    chk("wrap_a01", 32'(rd_log[3]), 1023);
    chk("wrap_a10", 32'(rd_log[6]), 0);
    chk("wrap_a11", 32'(rd_log[8]), 1);

    // reset during the ADD wait of element (1,0)
    preset(10'd0);
    mode = 2'b01; base_a = '0; start = 1'b1;
    for (int n = 1; n <= 39; n++) begin
      @(posedge clk); #1;
      if (n == 1) start = 1'b0;
    end
    chk("abort_busy_pre", 32'(busy), 1);
    chk("abort_add_a", f_add_a, F1);
    chk("abort_add_b", f_add_b, F3);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_outs", {28'd0, mem_en, mem_we, done, 1'b0} | 32'(mem_addr) | f_add_a | f_add_b | f_mul_a | f_mul_b, 0);
    reset = 1'b1;
    chk("abort_s0_partial", mem[BS], F1);
    chk("abort_s1_partial", mem[BS1], F2);
    @(posedge clk); #1;
    preset(10'd0);
    run(2'b01, 10'd0, 0, lat);
    chk("after_abort_lat", 32'(lat), 55);
    chk("after_abort_s0", mem[BS], F4);
    chk("after_abort_s1", mem[BS1], F6);

    // start pulsed (with another mode) mid-run is ignored
    preset(10'd0);
    run(2'b01, 10'd0, 10, lat);
    chk("poke_lat", 32'(lat), 55);
    chk("poke_s1", mem[BS1], F6);
    chk("poke_q0", mem[BQ], QPRE);
    repeat (5) @(posedge clk);
    #1;
    chk("poke_done_cnt", 32'(n_done), 1);
    chk("poke_idle", 32'(busy), 0);

    // start held high through done relaunches on the first IDLE cycle
    preset(10'd0);
    clr_mon();
    mode = 2'b01; start = 1'b1; n1 = -1; n2 = -1; idle_n = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (n1 > 0 && !busy) idle_n++;
      if (done && n1 < 0) n1 = n;
      else if (done) begin n2 = n; start = 1'b0; break; end
    end
    start = 1'b0;
    chk("hold_done1", 32'(n1), 55);
    chk("hold_done2", 32'(n2), 111);
    chk("hold_idle_cycles", 32'(idle_n), 1);
    chk("hold_s0", mem[BS], F4);
    chk("hold_s1", mem[BS1], F6);
    chk("hold_q0", mem[BQ], QPRE);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_idle_end", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
